// File: rtl/scope_trigger_capture.sv
// Trigger detect, decimated capture and column drain
// for the oscilloscope display path (clkWR domain).
module scope_trigger_capture #(
  parameter int VAL_RES     = 16,
  parameter int WIDTH       = 1024,
  parameter int LOG2_WIDTH  = 10,
  parameter int DECIM_WIDTH = 8,
  parameter int TIMEOUT     = 1000000,
  parameter int TO_WIDTH    = 20
) (
  input  logic                   clkWR,
  input  logic                   rst,
  input  logic [VAL_RES-1:0]     smp,
  input  logic                   smp_valid,
  input  logic [VAL_RES-1:0]     trig_level,
  input  logic                   trig_edge,
  input  logic                   trig_mode,
  input  logic [DECIM_WIDTH-1:0] decim,
  output logic [VAL_RES-1:0]     val,
  output logic                   val_valid,
  input  logic                   col_ready,
  output logic [LOG2_WIDTH-1:0]  col_idx,
  output logic                   frame_start,
  output logic                   triggered,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  localparam logic [LOG2_WIDTH-1:0] LAST =
    LOG2_WIDTH'(WIDTH - 1);
  localparam logic [TO_WIDTH-1:0] TO_LAST =
    TO_WIDTH'(TIMEOUT - 1);

  state_t st_q, st_d;

  logic [VAL_RES-1:0]     lvl_q;
  logic [VAL_RES-1:0]     prev_q;
  logic                   edge_q;
  logic                   mode_q;
  logic                   prev_ok;
  logic [DECIM_WIDTH-1:0] decim_q;
  logic [DECIM_WIDTH-1:0] dec_cnt;
  logic [TO_WIDTH-1:0]    to_cnt;
  logic [LOG2_WIDTH-1:0]  wr_addr;
  logic [LOG2_WIDTH-1:0]  rd_idx;
  logic [LOG2_WIDTH-1:0]  addr;
  logic                   vv_q;
  logic                   trig_q;
  logic [VAL_RES-1:0]     rd_q;
  logic [VAL_RES-1:0]     mem [WIDTH];

  logic rise, fall, hit, to_hit, xfer;
  logic arm, fire, we, re;

  assign rise = (prev_q < lvl_q) && (smp >= lvl_q);
  assign fall = (prev_q > lvl_q) && (smp <= lvl_q);
  assign hit = prev_ok && (edge_q ? fall : rise);
  assign to_hit = mode_q && (to_cnt == TO_LAST);
  assign xfer = vv_q & col_ready;

  always_ff @(posedge clkWR) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    arm  = 1'b0;
    fire = 1'b0;
    we   = 1'b0;
    re   = 1'b0;
    unique case (st_q)
      IDLE: begin
        st_d = WAIT_TRIG;
        arm  = 1'b1;
      end
      WAIT_TRIG: begin
        if (smp_valid && (hit || to_hit)) begin
          fire = 1'b1;
          we   = 1'b1;
          st_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (smp_valid && dec_cnt == '0) begin
          we = 1'b1;
          if (wr_addr == LAST) st_d = DRAIN;
        end
      end
      DRAIN: begin
        re = !vv_q;
        if (xfer && rd_idx == LAST) begin
          st_d = WAIT_TRIG;
          arm  = 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clkWR) begin
    if (rst) begin
      lvl_q   <= '0;
      prev_q  <= '0;
      edge_q  <= 1'b0;
      mode_q  <= 1'b0;
      prev_ok <= 1'b0;
      decim_q <= '0;
      dec_cnt <= '0;
      to_cnt  <= '0;
      wr_addr <= '0;
      rd_idx  <= '0;
      vv_q    <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      if (st_q == WAIT_TRIG) begin
        if (mode_q && to_cnt != TO_LAST)
          to_cnt <= to_cnt + 1'b1;
        if (smp_valid) begin
          prev_q  <= smp;
          prev_ok <= 1'b1;
        end
      end
      if (fire) begin
        trig_q  <= hit;
        dec_cnt <= decim_q;
      end
      if (st_q == CAPTURE && smp_valid)
        dec_cnt <= (dec_cnt == '0) ?
          decim_q : dec_cnt - 1'b1;
      if (we) wr_addr <= wr_addr + 1'b1;
      if (re) begin
        vv_q <= 1'b1;
      end else if (xfer) begin
        vv_q   <= 1'b0;
        rd_idx <= rd_idx + 1'b1;
      end
      // rearm: latch config, restart pointers
      if (arm) begin
        lvl_q   <= trig_level;
        edge_q  <= trig_edge;
        mode_q  <= trig_mode;
        decim_q <= decim;
        prev_ok <= 1'b0;
        to_cnt  <= '0;
        wr_addr <= '0;
        rd_idx  <= '0;
      end
    end
  end

  assign addr = (st_q == DRAIN) ? rd_idx : wr_addr;

  always_ff @(posedge clkWR) begin
    if (we) mem[addr] <= smp;
  end

  always_ff @(posedge clkWR) begin
    if (rst)     rd_q <= '0;
    else if (re) rd_q <= mem[addr];
  end

  assign val         = rd_q;
  assign val_valid   = vv_q;
  assign col_idx     = rd_idx;
  assign frame_start = vv_q && (rd_idx == '0);
  assign triggered   = trig_q;
  assign state       = st_q;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Directed bench for scope_trigger_capture
// (8 columns, 16-cycle auto timeout).
module tb_scope_trigger_capture;

  logic        clkWR = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] smp = '0;
  logic        smp_valid = 1'b0;
  logic [15:0] trig_level = '0;
  logic        trig_edge = 1'b0;
  logic        trig_mode = 1'b0;
  logic [7:0]  decim = '0;
  logic [15:0] val;
  logic        val_valid;
  logic        col_ready = 1'b1;
  logic [2:0]  col_idx;
  logic        frame_start;
  logic        triggered;
  logic [1:0]  state;

  int n_chk = 0;
  int n_fail = 0;

  bit ramp_on = 1'b0;
  bit ramp_tog = 1'b0;
  int ramp_step = 0;

  logic [31:0] q[$];

  always #5 clkWR = ~clkWR;

  scope_trigger_capture #(
    .VAL_RES(16), .WIDTH(8), .LOG2_WIDTH(3),
    .DECIM_WIDTH(8), .TIMEOUT(16), .TO_WIDTH(5)
  ) dut (
    .clkWR(clkWR), .rst(rst), .smp(smp),
    .smp_valid(smp_valid),
    .trig_level(trig_level), .trig_edge(trig_edge),
    .trig_mode(trig_mode), .decim(decim),
    .val(val), .val_valid(val_valid),
    .col_ready(col_ready), .col_idx(col_idx),
    .frame_start(frame_start),
    .triggered(triggered), .state(state)
  );

  // transfers seen at the edge that follows
  always @(negedge clkWR) begin
    if (!rst && val_valid && col_ready)
      q.push_back({12'd0, frame_start, col_idx, val});
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkWR);
    #1;
    if (ramp_on) begin
      if (smp_valid) smp = smp + 16'(ramp_step);
      if (ramp_tog) smp_valid = ~smp_valid;
    end
  endtask

  task automatic reset_dut(input bit do_chk);
    ramp_on = 1'b0;
    smp_valid = 1'b0;
    col_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    if (do_chk) begin
      check("rst_val", 32'(val), 0);
      check("rst_vv", 32'(val_valid), 0);
      check("rst_idx", 32'(col_idx), 0);
      check("rst_fs", 32'(frame_start), 0);
      check("rst_trig", 32'(triggered), 0);
      check("rst_state", 32'(state), 0);
    end
    rst = 1'b0;
    tick();
    if (do_chk) check("rst_arm", 32'(state), 1);
  endtask

  task automatic start_ramp(input int v0, input int st,
                            input bit tog);
    smp = 16'(v0);
    ramp_step = st;
    ramp_tog = tog;
    smp_valid = 1'b1;
    ramp_on = 1'b1;
  endtask

  task automatic run_frame(input string tag,
                           input int base, input int step,
                           input bit exp_trig,
                           input bit stall);
    bit stalled = 1'b0;
    int e;
    q.delete();
    col_ready = 1'b1;
    for (int c = 0; c < 400 && q.size() < 8; c++) begin
      tick();
      if (state == 2'd3) begin
        ramp_on = 1'b0;
        smp_valid = 1'b0;
      end
      if (stall && !stalled && val_valid
          && col_idx == 3'd3) begin
        stalled = 1'b1;
        col_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          check({tag, "_hold_val"}, 32'(val),
                (base + 3 * step) & 32'hFFFF);
          check({tag, "_hold_idx"}, 32'(col_idx), 3);
          check({tag, "_hold_vv"}, 32'(val_valid), 1);
        end
        col_ready = 1'b1;
      end
    end
    check({tag, "_count"}, q.size(), 8);
    check({tag, "_rearm"}, 32'(state), 1);
    check({tag, "_vv_end"}, 32'(val_valid), 0);
    check({tag, "_trig"}, 32'(triggered), 32'(exp_trig));
    if (stall) check({tag, "_stalled"}, 32'(stalled), 1);
    for (int k = 0; k < q.size() && k < 8; k++) begin
      e = (base + k * step) & 32'hFFFF;
      check($sformatf("%s_val%0d", tag, k),
            32'(q[k][15:0]), e);
      check($sformatf("%s_idx%0d", tag, k),
            32'(q[k][18:16]), k);
      check($sformatf("%s_fs%0d", tag, k),
            32'(q[k][19]), 32'(k == 0));
    end
  endtask

  initial begin
    int bad;

    // rising edge, every sample
    trig_level = 16'd1000;
    trig_edge = 1'b0;
    trig_mode = 1'b0;
    decim = 8'd0;
    reset_dut(1'b1);
    start_ramp(0, 100, 1'b0);
    run_frame("rise", 1000, 100, 1'b1, 1'b0);

    // decimation, continuous and gapped input
    trig_level = 16'd50;
    decim = 8'd2;
    reset_dut(1'b0);
    start_ramp(0, 1, 1'b0);
    run_frame("dec", 50, 3, 1'b1, 1'b0);
    reset_dut(1'b0);
    start_ramp(0, 1, 1'b1);
    run_frame("dec_gap", 50, 3, 1'b1, 1'b0);

    // backpressure on column 3
    trig_level = 16'd1000;
    decim = 8'd0;
    reset_dut(1'b0);
    start_ramp(0, 100, 1'b0);
    run_frame("bp", 1000, 100, 1'b1, 1'b1);

    // normal mode never triggers on a flat input
    reset_dut(1'b0);
    start_ramp(0, 0, 1'b0);
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (state != 2'd1) bad++;
    end
    check("normal_wait", bad, 0);

    // auto mode forces after the timeout
    trig_mode = 1'b1;
    reset_dut(1'b0);
    start_ramp(0, 0, 1'b0);
    for (int c = 0; c < 15; c++) tick();
    check("auto_pre", 32'(state), 1);
    tick();
    check("auto_fire", 32'(state), 2);
    run_frame("auto", 0, 0, 1'b0, 1'b0);

    // falling edge, reset during column 4
    trig_mode = 1'b0;
    trig_edge = 1'b1;
    trig_level = 16'd1500;
    reset_dut(1'b0);
    start_ramp(2000, -100, 1'b0);
    q.delete();
    for (int c = 0; c < 200; c++) begin
      tick();
      if (state == 2'd3) begin
        ramp_on = 1'b0;
        smp_valid = 1'b0;
      end
      if (val_valid && col_idx == 3'd4) break;
    end
    check("fall_at4", 32'(val_valid && col_idx == 3'd4), 1);
    check("fall_n", q.size(), 4);
    if (q.size() > 0)
      check("fall_col0", 32'(q[0][15:0]), 1500);
    rst = 1'b1;
    tick();
    check("fall_rst_vv", 32'(val_valid), 0);
    check("fall_rst_st", 32'(state), 0);
    check("fall_rst_n", q.size(), 4);
    rst = 1'b0;
    tick();
    check("fall_rearm", 32'(state), 1);
    start_ramp(2000, -100, 1'b0);
    run_frame("fall", 1500, -100, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
